// File: rtl/per_arb_pkg.sv
// per_arb_pkg: shared width helpers and round-robin search for the per-slave arbiter
package per_arb_pkg;
    localparam int MAX_N = 64;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction
    function automatic int rr_pick(input logic [MAX_N-1:0] req, input int n, input int ptr);
        int w;
        w = -1;
        for (int k = MAX_N - 1; k >= 0; k--)
            if (k < n && req[(ptr + k) % n]) w = (ptr + k) % n;
        return w;
    endfunction
endpackage

// File: rtl/per_arb_id_fifo.sv
// per_arb_id_fifo: synchronous FIFO holding the master index of each outstanding transaction
module per_arb_id_fifo
    import per_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        full = cnt_q == CW'(DEPTH);
        empty = cnt_q == '0;
        do_push = push & !full;
        do_pop = pop & !empty;
        head = mem_q[rd_q];
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d = do_push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/per_slave_rr_arbiter.sv
// per_slave_rr_arbiter: round-robin share of one peripheral slave with in-order response routing
module per_slave_rr_arbiter
    import per_arb_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_MASTER-1:0]                  req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  add_i,
    input  logic [N_MASTER-1:0]                  wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    be_i,
    output logic [N_MASTER-1:0]                  gnt_o,
    output logic                                 req_o,
    output logic [ADDR_WIDTH-1:0]                add_o,
    output logic                                 wen_o,
    output logic [DATA_WIDTH-1:0]                wdata_o,
    output logic [BE_WIDTH-1:0]                  be_o,
    input  logic                                 gnt_i,
    input  logic                                 r_valid_i,
    input  logic [DATA_WIDTH-1:0]                r_rdata_i,
    input  logic                                 r_opc_i,
    output logic [N_MASTER-1:0]                  r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,
    output logic                                 resp_err_o
);
    localparam int IW = idx_w(N_MASTER);
    localparam logic [N_MASTER-1:0] ONE = {{(N_MASTER - 1){1'b0}}, 1'b1};
    logic [IW-1:0] ptr_q, ptr_d, win_idx, head;
    logic has_win, full, empty, accept, pop, err_q, err_d;
    int winner;
    per_arb_id_fifo #(
        .DEPTH(MAX_OUTSTANDING),
        .WIDTH(IW)
    ) u_id_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .pop  (pop),
        .din  (win_idx),
        .head (head),
        .full (full),
        .empty(empty)
    );
    always_comb begin
        winner = rr_pick(MAX_N'(req_i), N_MASTER, int'(ptr_q));
        has_win = winner >= 0;
        win_idx = IW'(winner);
        // Full blocks acceptance even if a response frees a slot this cycle
        req_o = |req_i & !full;
        accept = req_o & gnt_i;
        gnt_o = accept ? ONE << win_idx : '0;
        add_o = has_win ? add_i[win_idx] : '0;
        wen_o = has_win ? wen_i[win_idx] : 1'b0;
        wdata_o = has_win ? wdata_i[win_idx] : '0;
        be_o = has_win ? be_i[win_idx] : '0;
        ptr_d = accept ? ((win_idx == IW'(N_MASTER - 1)) ? '0 : win_idx + 1'b1) : ptr_q;
        pop = r_valid_i & !empty;
        r_valid_o = pop ? ONE << head : '0;
        err_d = err_q | (r_valid_i & empty);
        r_rdata_o = r_rdata_i;
        r_opc_o = r_opc_i;
        resp_err_o = err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_per_slave_rr_arbiter.sv
// tb_per_slave_rr_arbiter: directed scenarios plus randomized traffic against a queue-based reference model
module tb_per_slave_rr_arbiter;
    localparam int N = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MO = 2;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req_i, wen_i, gnt_o, r_valid_o;
    logic [N-1:0][AW-1:0] add_i;
    logic [N-1:0][DW-1:0] wdata_i;
    logic [N-1:0][BW-1:0] be_i;
    logic req_o, wen_o, gnt_i, r_valid_i, r_opc_i, r_opc_o, resp_err_o;
    logic [AW-1:0] add_o;
    logic [DW-1:0] wdata_o, r_rdata_i, r_rdata_o;
    logic [BW-1:0] be_o;
    int m_ptr;
    int m_q[$];
    bit m_err;
    int n_chk, n_fail;

    always #5 clk = ~clk;

    per_slave_rr_arbiter #(
        .N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i),
        .be_i(be_i), .gnt_o(gnt_o), .req_o(req_o), .add_o(add_o), .wen_o(wen_o),
        .wdata_o(wdata_o), .be_o(be_o), .gnt_i(gnt_i), .r_valid_i(r_valid_i),
        .r_rdata_i(r_rdata_i), .r_opc_i(r_opc_i), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .resp_err_o(resp_err_o)
    );

    function automatic int m_win();
        for (int k = 0; k < N; k++)
            if (req_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic tick();
        int w;
        bit acc, pv;
        w = m_win();
        acc = (req_i != 0) && (m_q.size() < MO) && gnt_i;
        pv = r_valid_i && (m_q.size() > 0);
        if (r_valid_i && m_q.size() == 0) m_err = 1'b1;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ptr = 0;
            m_err = 1'b0;
        end else begin
            if (pv) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(w);
                m_ptr = (w + 1) % N;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        req_i = '0; gnt_i = 1'b0; r_valid_i = 1'b0; r_rdata_i = '0; r_opc_i = 1'b0;
        for (int m = 0; m < N; m++) begin
            add_i[m] = 32'h1000_0000 + AW'(m);
            wen_i[m] = m[0];
            wdata_i[m] = 32'hD000_0000 + DW'(m);
            be_i[m] = BW'(m + 1);
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt_o); end
        n_chk++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req_o); end
        n_chk++; if ({add_o, wdata_o, be_o, wen_o} !== '0) begin n_fail++; $display("FAIL reset_bus: got %h/%h/%h/%b expected all 0", add_o, wdata_o, be_o, wen_o); end
        n_chk++; if (r_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", r_valid_o); end
        n_chk++; if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err_o); end
    endtask

    task automatic test_single();
        req_i = 4'b0100; gnt_i = 1'b1; #1;
        n_chk++; if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b expected 0100", gnt_o); end
        n_chk++; if (add_o !== 32'h1000_0002 || wdata_o !== 32'hD000_0002 || be_o !== 4'd3 || wen_o !== 1'b0)
            begin n_fail++; $display("FAIL single_bus: got %h/%h/%h/%b expected 10000002/d0000002/3/0", add_o, wdata_o, be_o, wen_o); end
        tick();
        req_i = '0; gnt_i = 1'b0; r_valid_i = 1'b1; r_rdata_i = 32'hCAFE_0001; #1;
        n_chk++; if (r_valid_o !== 4'b0100) begin n_fail++; $display("FAIL single_rvalid: got %b expected 0100", r_valid_o); end
        n_chk++; if (r_rdata_o !== 32'hCAFE_0001) begin n_fail++; $display("FAIL single_rdata: got %h expected cafe0001", r_rdata_o); end
        tick();
        r_valid_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        req_i = 4'b1111; gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r_valid_i = (i > 0); #1;
            exp = 4'b0001 << (i % N);
            n_chk++; if (gnt_o !== exp) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt_o, exp); end
            if (i > 0) begin
                exp = 4'b0001 << ((i - 1) % N);
                n_chk++; if (r_valid_o !== exp) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, r_valid_o, exp); end
            end
            tick();
        end
        req_i = '0; gnt_i = 1'b0; r_valid_i = 1'b1; #1;
        n_chk++; if (r_valid_o !== 4'b0001) begin n_fail++; $display("FAIL rr_last_rvalid: got %b expected 0001", r_valid_o); end
        tick();
        r_valid_i = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        req_i = 4'b1111; gnt_i = 1'b1; #1;
        n_chk++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL full_gnt0: got %b expected 0001", gnt_o); end
        tick(); #1;
        n_chk++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL full_gnt1: got %b expected 0010", gnt_o); end
        tick(); #1;
        n_chk++; if (req_o !== 1'b0 || gnt_o !== 4'b0000) begin n_fail++; $display("FAIL full_block: got req %b gnt %b expected req 0 gnt 0000", req_o, gnt_o); end
        r_valid_i = 1'b1; #1;
        n_chk++; if (r_valid_o !== 4'b0001 || req_o !== 1'b0 || gnt_o !== 4'b0000)
            begin n_fail++; $display("FAIL full_pop_nobypass: got rv %b req %b gnt %b expected rv 0001 req 0 gnt 0000", r_valid_o, req_o, gnt_o); end
        tick();
        r_valid_i = 1'b0; #1;
        n_chk++; if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL full_resume: got %b expected 0100", gnt_o); end
        tick();
        req_i = '0; gnt_i = 1'b0; r_valid_i = 1'b1; #1;
        n_chk++; if (r_valid_o !== 4'b0010) begin n_fail++; $display("FAIL full_drain0: got %b expected 0010", r_valid_o); end
        tick(); #1;
        n_chk++; if (r_valid_o !== 4'b0100) begin n_fail++; $display("FAIL full_drain1: got %b expected 0100", r_valid_o); end
        tick();
        r_valid_i = 1'b0;
    endtask

    task automatic test_gnt_stall();
        do_reset();
        req_i = 4'b1010; gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (gnt_o !== 4'b0000 || req_o !== 1'b1) begin n_fail++; $display("FAIL stall[%0d]: got gnt %b req %b expected gnt 0000 req 1", i, gnt_o, req_o); end
            tick();
        end
        gnt_i = 1'b1; #1;
        n_chk++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL stall_first: got %b expected 0010", gnt_o); end
        tick(); #1;
        n_chk++; if (gnt_o !== 4'b1000) begin n_fail++; $display("FAIL stall_second: got %b expected 1000", gnt_o); end
        tick();
        req_i = '0; gnt_i = 1'b0; r_valid_i = 1'b1; #1;
        n_chk++; if (r_valid_o !== 4'b0010) begin n_fail++; $display("FAIL stall_resp0: got %b expected 0010", r_valid_o); end
        tick(); #1;
        n_chk++; if (r_valid_o !== 4'b1000) begin n_fail++; $display("FAIL stall_resp1: got %b expected 1000", r_valid_o); end
        tick();
        r_valid_i = 1'b0;
    endtask

    task automatic test_err();
        r_valid_i = 1'b1; #1;
        n_chk++; if (r_valid_o !== 4'b0000) begin n_fail++; $display("FAIL err_rvalid: got %b expected 0000", r_valid_o); end
        tick();
        r_valid_i = 1'b0; #1;
        n_chk++; if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", resp_err_o); end
        repeat (3) tick();
        n_chk++; if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", resp_err_o); end
    endtask

    task automatic test_reset_mid();
        do_reset(); #1;
        n_chk++; if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL mid_err_clear: got %b expected 0", resp_err_o); end
        req_i = 4'b1111; gnt_i = 1'b1;
        tick(); tick();
        req_i = '0; gnt_i = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; r_valid_i = 1'b1; #1;
        n_chk++; if (r_valid_o !== 4'b0000) begin n_fail++; $display("FAIL mid_stale_rvalid: got %b expected 0000", r_valid_o); end
        tick();
        r_valid_i = 1'b0; #1;
        n_chk++; if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL mid_stale_err: got %b expected 1", resp_err_o); end
        req_i = 4'b1111; gnt_i = 1'b1; #1;
        n_chk++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL mid_regrant: got %b expected 0001", gnt_o); end
        tick();
        req_i = '0; gnt_i = 1'b0;
    endtask

    task automatic test_random();
        int w;
        logic exp_req;
        logic [N-1:0] exp_gnt, exp_rv;
        logic [AW+DW+BW:0] exp_bus;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_i = N'($urandom);
            gnt_i = ($urandom_range(0, 3) != 0);
            r_valid_i = ($urandom_range(0, 2) != 0) && (m_q.size() > 0);
            r_rdata_i = $urandom;
            r_opc_i = 1'($urandom_range(0, 1));
            for (int m = 0; m < N; m++) begin
                add_i[m] = $urandom; wdata_i[m] = $urandom;
                be_i[m] = BW'($urandom); wen_i[m] = 1'($urandom_range(0, 1));
            end
            #1;
            w = m_win();
            exp_req = (req_i != 0) && (m_q.size() < MO);
            exp_gnt = (exp_req && gnt_i) ? (4'b0001 << w) : 4'b0000;
            exp_bus = (w >= 0) ? {add_i[w], wen_i[w], wdata_i[w], be_i[w]} : '0;
            exp_rv = (r_valid_i && m_q.size() > 0) ? (4'b0001 << m_q[0]) : 4'b0000;
            n_chk++; if ({req_o, gnt_o} !== {exp_req, exp_gnt}) begin n_fail++; $display("FAIL rand_gnt[%0d]: got req %b gnt %b expected req %b gnt %b", i, req_o, gnt_o, exp_req, exp_gnt); end
            n_chk++; if ({add_o, wen_o, wdata_o, be_o} !== exp_bus) begin n_fail++; $display("FAIL rand_bus[%0d]: got %h expected %h", i, {add_o, wen_o, wdata_o, be_o}, exp_bus); end
            n_chk++; if ({r_valid_o, r_rdata_o, r_opc_o} !== {exp_rv, r_rdata_i, r_opc_i}) begin n_fail++; $display("FAIL rand_resp[%0d]: got rv %b data %h opc %b expected rv %b data %h opc %b", i, r_valid_o, r_rdata_o, r_opc_o, exp_rv, r_rdata_i, r_opc_i); end
            n_chk++; if (resp_err_o !== m_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", i, resp_err_o, m_err); end
            tick();
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_ptr = 0; m_err = 1'b0; rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_gnt_stall();
        test_err();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/per_slave_rr_arbiter.md
Name: per_slave_rr_arbiter

Overview:
Shares one peripheral slave port between N_MASTER requesters on the peripheral interconnect. It performs round-robin arbitration with grant-based flow control and tracks the requester of each outstanding transaction. Each slave response is routed back only to the master that issued the request. It sits between the per-master request/response blocks and a single peripheral target.

Parameters:
N_MASTER, 4, number of requesting masters (>=2)
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, write/read data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_i  in  N_MASTER  per-master request
add_i  in  N_MASTER x ADDR_WIDTH  per-master address
wen_i  in  N_MASTER  per-master write enable, active low (1 = read)
wdata_i  in  N_MASTER x DATA_WIDTH  per-master write data
be_i  in  N_MASTER x BE_WIDTH  per-master byte enable
gnt_o  out  N_MASTER  per-master grant (one-hot or zero)
req_o  out  1  request to slave
add_o  out  ADDR_WIDTH  muxed address
wen_o  out  1  muxed write enable
wdata_o  out  DATA_WIDTH  muxed write data
be_o  out  BE_WIDTH  muxed byte enable
gnt_i  in  1  slave grant
r_valid_i  in  1  slave response valid
r_rdata_i  in  DATA_WIDTH  slave response data
r_opc_i  in  1  slave response error/opcode
r_valid_o  out  N_MASTER  per-master response valid (one-hot or zero)
r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters
r_opc_o  out  1  response opcode, broadcast to all masters
resp_err_o  out  1  sticky: response received with nothing outstanding

Behaviour:
- Reset (rst=1 at clk edge):
  - RR pointer = 0; ID FIFO empty; outstanding count = 0; resp_err_o = 0.
  - All combinational outputs are 0 while no request or response is present.
- Arbitration, combinational:
  - Winner = first asserted req_i at or after the pointer, searching cyclically upward.
  - full = (count == MAX_OUTSTANDING).
  - req_o = |req_i & !full.
  - add_o, wen_o, wdata_o and be_o carry the winner's fields; they are 0 when there is no winner.
  - gnt_o[winner] = gnt_i & req_o; all other gnt_o bits are 0.
- Handshake: a transaction is accepted in a cycle where req_o & gnt_i.
  - On accept: push winner index into the ID FIFO; pointer <= (winner+1) mod N_MASTER.
  - The pointer is held when nothing is accepted. A master that is not granted keeps its request; the arbiter does not require the request to be held stable.
- Full: req_o is forced low and no master is granted. A pop in the same cycle does not bypass the full condition; acceptance resumes the next cycle.
- Responses:
  - Slave latency is >= 1 cycle after accept. Responses arrive in acceptance order.
  - On r_valid_i with FIFO non-empty: r_valid_o = one-hot(FIFO head), combinational, same cycle; pop head.
  - r_rdata_o and r_opc_o pass through from the slave at all times.
- Error: r_valid_i with FIFO empty sets resp_err_o and drives r_valid_o = 0.
  - A push in that same cycle does not count as outstanding for this check.
  - resp_err_o clears only on rst.
- Simultaneous push and pop: count is unchanged; the FIFO read and write pointers both advance.
- Pointer wrap-around at N_MASTER-1 goes to 0. FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction: all outstanding IDs are discarded. Any later stale r_valid_i raises resp_err_o.

Decomposition:
- Package per_arb_pkg:
  - function for the master index width, $clog2(N_MASTER) with a minimum of 1;
  - function for the FIFO count width, $clog2(MAX_OUTSTANDING+1);
  - RR search helper function.
- Sub-module per_arb_id_fifo: synchronous FIFO of master indices.
  - Parameters: depth and width.
  - Ports: push, pop, head, full, empty.
  - Same-cycle push/pop is supported when neither full nor empty.

Test Plan:
- Single master 2, gnt_i=1, response 1 cycle later with rdata=0xCAFE0001 -> gnt_o=0b0100 at the request cycle; r_valid_o=0b0100 with r_rdata_o=0xCAFE0001.
- All four masters request continuously, gnt_i=1, one response per cycle -> grant sequence 0,1,2,3,0; r_valid_o follows the same order, one cycle later.
- MAX_OUTSTANDING=2 with responses withheld -> two accepts, then req_o=0 and gnt_o=0. A response in the full cycle pops one entry; the next accept happens only on the following cycle.
- gnt_i=0 for 3 cycles with masters 1 and 3 requesting -> pointer holds, gnt_o=0. When gnt_i rises, master 1 is granted first, then master 3.
- r_valid_i pulsed with nothing outstanding -> r_valid_o=0, resp_err_o=1 and stays 1 until rst.
- Assert rst with 2 outstanding, then deliver one response -> resp_err_o=1, r_valid_o=0; the next request is granted starting from master 0.
